// File: rtl/dm_pkg.sv
// Shared definitions for the dm_banked data memory.
//   Size codes   : encoding of the req_size field.
//   Error codes  : encoding of the rsp_err field.
//   state_e      : the controller state encoding.
//   RD_LAT_MIN/MAX : legal bounds for the read latency parameter.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/dm_lane_ctrl.sv
// Combinational byte-lane logic for dm_banked.
//   i_size     : access size code (byte/half/word/illegal)
//   i_sign     : sign-extend loads when 1
//   i_byte_off : byte offset of the access inside its word
//   i_wdata    : right-aligned store data
//   i_word     : current contents of the addressed word
//   o_be       : byte enables of the store (0 for illegal size)
//   o_merged   : i_word with the enabled bytes replaced by store data
//   o_rdata    : extracted and extended load data
module dm_lane_ctrl
    import dm_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata
);

    logic [31:0] w_wlanes;
    logic [31:0] w_shifted;

    // Move the addressed byte/half down to bit 0 for extraction.
    assign w_shifted = i_word >> {i_byte_off, 3'b000};

    always_comb begin
        o_be     = 4'b0000;
        w_wlanes = 32'h0;
        o_rdata  = 32'h0;
        case (i_size)
            SZ_BYTE: begin
                o_be     = 4'b0001 << i_byte_off;
                w_wlanes = {4{i_wdata[7:0]}};
                o_rdata  = {{24{i_sign & w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                o_be     = i_byte_off[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{i_wdata[15:0]}};
                o_rdata  = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
            end
            SZ_WORD: begin
                o_be     = 4'b1111;
                w_wlanes = i_wdata;
                o_rdata  = i_word;
            end
            default: begin
                o_be     = 4'b0000;
                w_wlanes = 32'h0;
                o_rdata  = 32'h0;
            end
        endcase
    end

    always_comb begin
        o_merged = i_word;
        for (int i = 0; i < 4; i++) begin
            if (o_be[i]) begin
                o_merged[8*i +: 8] = w_wlanes[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_banked.sv
// Word-organised data memory with a zero-fill sweep after reset and a
// fully pipelined request/response interface of fixed latency RD_LAT.
//   clk, reset          : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only after the sweep)
//   req_we, req_size, req_sign, pc, addr, wdata : request fields
//   rsp_valid, rdata, rsp_err : response, valid for one cycle, zero otherwise
//   init_done           : the clear sweep has finished
module dm_banked
    import dm_pkg::*;
#(
    parameter int          DEPTH     = 3072,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RD_LAT    = 1,
    parameter bit          LOG_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic [1:0]  rsp_err,
    output logic        init_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Out-of-range latency values are pulled back into the legal window.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic [31:0]      r_mem [DEPTH];
    state_e           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_init_idx, w_init_idx_nxt;

    logic [31:0] w_offset;
    logic        w_in_range;
    logic [1:0]  w_err;
    logic        w_accept;
    logic        w_store;
    logic [31:0] w_rd_word;
    logic [3:0]  w_be;
    logic [31:0] w_merged;
    logic [31:0] w_load;
    logic [31:0] w_rsp_data;

    logic [31:0]    r_data_p [LAT];
    logic [1:0]     r_err_p  [LAT];
    logic [LAT-1:0] r_vld_p;

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_INIT;
            r_init_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_idx <= w_init_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_idx_nxt = r_init_idx;
        case (r_state)
            ST_INIT: begin
                if (r_init_idx == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt    = ST_RUN;
                    w_init_idx_nxt = '0;
                end else begin
                    w_init_idx_nxt = r_init_idx + 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign req_ready = (r_state == ST_RUN);
    assign init_done = (r_state == ST_RUN);
    assign w_accept  = req_valid && (r_state == ST_RUN);

    // ---------------- request decode ----------------
    // BASE_ADDR is word aligned, so the low offset bits equal addr[1:0]. An
    // address below BASE_ADDR wraps to a huge index and lands out of range.
    assign w_offset   = addr - BASE_ADDR;
    assign w_in_range = (w_offset[31:2] < 30'(DEPTH));

    always_comb begin
        w_err = ERR_OK;
        if (req_size == SZ_ILL)
            w_err = ERR_SIZE;
        else if ((req_size == SZ_HALF && w_offset[0]) ||
                 (req_size == SZ_WORD && w_offset[1:0] != 2'b00))
            w_err = ERR_MISALIGN;
        else if (!w_in_range)
            w_err = ERR_RANGE;
    end

    assign w_rd_word = w_in_range ? r_mem[w_offset[IDX_W+1:2]] : 32'h0;

    dm_lane_ctrl u_lane (
        .i_size     (req_size),
        .i_sign     (req_sign),
        .i_byte_off (w_offset[1:0]),
        .i_wdata    (wdata),
        .i_word     (w_rd_word),
        .o_be       (w_be),
        .o_merged   (w_merged),
        .o_rdata    (w_load)
    );

    assign w_store    = w_accept && req_we && (w_err == ERR_OK) && (w_be != 4'b0000);
    assign w_rsp_data = (w_err == ERR_OK && !req_we) ? w_load : 32'h0;

    // ---------------- memory array (sweep has priority, no accepts in INIT) ----------------
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_idx] <= 32'h0;
        end else if (w_store) begin
            r_mem[w_offset[IDX_W+1:2]] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (LOG_EN && reset && w_store) begin
            $display("@%08h: *%08h <= %08h", pc, {addr[31:2], 2'b00}, w_merged);
        end
    end

    // ---------------- response pipeline p0 .. p(LAT-1) ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_accept;
            for (int i = 1; i < LAT; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_data_p[0] <= w_rsp_data;
        r_err_p[0]  <= w_err;
        for (int i = 1; i < LAT; i++) begin
            r_data_p[i] <= r_data_p[i-1];
            r_err_p[i]  <= r_err_p[i-1];
        end
    end

    // Data stages are not reset; gating on the valid bit keeps outputs at 0.
    assign rsp_valid = r_vld_p[LAT-1];
    assign rdata     = rsp_valid ? r_data_p[LAT-1] : 32'h0;
    assign rsp_err   = rsp_valid ? r_err_p[LAT-1]  : 2'b00;

endmodule

// File: doc/dm_banked.md
DM_BANKED -- requirements
Module: dm_banked

Interface
REQ-001 SHALL have parameter DEPTH, default 3072; memory size in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000; byte address of word 0.
REQ-003 SHALL have parameter RD_LAT, default 1, legal range 1..3; cycles from request accept to response.
REQ-004 SHALL have parameter LOG_EN, default 1; enables the write log line.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit; asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, 1 bit; a request is presented.
REQ-008 SHALL have port req_ready, output, 1 bit; the block can accept a request.
REQ-009 SHALL have port req_we, input, 1 bit; 1 is a store, 0 is a load.
REQ-010 SHALL have port req_size, input, 2 bits; 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have port req_sign, input, 1 bit; sign-extend loads when 1.
REQ-012 SHALL have port pc, input, 32 bits; used for logging only.
REQ-013 SHALL have port addr, input, 32 bits; byte address.
REQ-014 SHALL have port wdata, input, 32 bits; store data, right-aligned.
REQ-015 SHALL have port rsp_valid, output, 1 bit; a response is present for one cycle.
REQ-016 SHALL have port rdata, output, 32 bits; extended load data, 0 for stores and errors.
REQ-017 SHALL have port rsp_err, output, 2 bits; 00 ok, 01 misaligned, 10 out of range, 11 illegal size.
REQ-018 SHALL have port init_done, output, 1 bit; the clear sweep has finished.

Function
REQ-019 SHALL implement FSM states INIT and RUN; reset enters INIT; INIT moves to RUN the cycle after word DEPTH-1 is cleared; RUN is held until reset.
REQ-020 SHALL in INIT write zero to one word per cycle, index 0 up to DEPTH-1, so the sweep takes DEPTH cycles; req_ready=0 and init_done=0 throughout INIT.
REQ-021 SHALL in RUN drive req_ready=1 and init_done=1; a request is accepted on any edge with req_valid=1 and req_ready=1, one per cycle, fully pipelined.
REQ-022 SHALL for every accepted request assert rsp_valid exactly RD_LAT cycles after the accept edge, in request order; a response cannot be back-pressured.
REQ-023 SHALL compute the word index as (addr-BASE_ADDR)>>2 and use little-endian byte lanes: byte n occupies bits 8n+7:8n, and the half lane is selected by addr[1].
REQ-024 SHALL apply error priority illegal size > misaligned (half with addr[0]=1, word with addr[1:0]!=0) > out of range (index >= DEPTH, including addr below BASE_ADDR).
REQ-025 SHALL on an erroring request perform no memory write and respond with rdata=0 and the matching rsp_err.
REQ-026 SHALL on a legal store merge only the enabled bytes into the addressed word at the accept edge; other bytes stay unchanged.
REQ-027 SHALL on a legal load sample the addressed word as it stands after all stores accepted on earlier edges, extract the lane, then zero- or sign-extend it per req_sign.
REQ-028 SHALL when LOG_EN=1 print "@<pc>: *<word-aligned addr> <= <merged word>" in 8-digit hex for every legal store.
REQ-029 SHALL leave rdata and rsp_err at 0 in every cycle where rsp_valid=0.

Reset
REQ-030 SHALL on reset assertion immediately drive req_ready=0, rsp_valid=0, rdata=0, rsp_err=00, init_done=0 and clear all pipeline valid bits; in-flight requests are dropped with no response.
REQ-031 SHALL on reset assertion mid-sweep or mid-RUN restart INIT from index 0 at the first clock edge after deassertion.

Structure
REQ-032 SHALL take size codes, error codes, state encoding and RD_LAT bounds from shared package dm_pkg.
REQ-033 SHALL place store byte-enable and merge generation and load lane extraction and extension in one combinational sub-module, dm_lane_ctrl.

Verification
REQ-034 SHALL verify reset released with DEPTH=16: init_done rises after 16 cycles, and a word load at 0x3C returns 0 with err 00.
REQ-035 SHALL verify sw 0x11223344 to 0x8, then sb 0xAA to 0x9, then lw 0x8: the load returns 0x1122AA44 and two log lines appear.
REQ-036 SHALL verify lb signed at 0x9 returns 0xFFFFFFAA, lbu returns 0x000000AA, and lh signed at 0xA returns 0x00001122.
REQ-037 SHALL verify sh to 0x3 returns err 01 and leaves memory unchanged; size 11 returns err 11; with DEPTH=16, lw at 0x40 returns err 10.
REQ-038 SHALL verify back-to-back requests with RD_LAT=3: responses arrive 3 cycles after each accept, in order, one per cycle.
REQ-039 SHALL verify reset asserted with 2 requests in flight: no response is produced, and the sweep restarts from index 0.
